// File: rtl/sm_mul32.sv
// Purpose: 32-bit sign-magnitude multiplier built on a shift-and-add datapath, one multiplier bit per cycle.
// Latency: the operand pair is accepted at edge E0 and out_valid rises after edge E31 (fixed, independent of data).
// Backpressure: while out_ready=0 the result is held indefinitely, and new operands are taken only from IDLE.
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   in_valid/in_ready     operand handshake (op1 = multiplicand, op2 = multiplier, both sign-magnitude)
//   out_valid/out_ready   result handshake
//   prod, ovf             sign-magnitude product (low 31 magnitude bits); ovf = magnitude wider than 31 bits
module sm_mul32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] prod,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q;
  logic        sign_q;
  logic [30:0] mcand_q;
  logic [30:0] mplier_q;
  logic [61:0] acc_q;
  logic [61:0] acc_d;
  logic [4:0]  cnt_q;
  logic [31:0] prod_q;
  logic        ovf_q;
  logic        in_ready_q;
  logic        out_valid_q;

  // One partial product per cycle, added at full 62-bit width so that the
  // overflow flag can see every bit above the 31-bit magnitude.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[cnt_q]) begin
      acc_d = acc_q + ({31'd0, mcand_q} << cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      prod_q      <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q     <= op1[31] ^ op2[31];
            mcand_q    <= op1[30:0];
            mplier_q   <= op2[30:0];
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          // The last partial product is folded in on the same edge that
          // publishes the result, so the result is taken from acc_d.
          if (cnt_q == 5'd30) begin
            // Sign is dropped for a zero magnitude so -0 is never produced.
            prod_q      <= {sign_q & (|acc_d[30:0]), acc_d[30:0]};
            ovf_q       <= |acc_d[61:31];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign prod      = prod_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sm_mul32.sv
module tb_sm_mul32;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] prod;
  logic        ovf;

  int n_chk = 0;
  int n_err = 0;

  sm_mul32 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op1      (op1),
    .op2      (op2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .prod     (prod),
    .ovf      (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {ovf, prod}.
  function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [61:0] m;
    m = {31'd0, a[30:0]} * {31'd0, b[30:0]};
    ref_mul = {|m[61:31], (a[31] ^ b[31]) && (m[30:0] != 31'd0), m[30:0]};
  endfunction

  // Transaction-level timing model: idle -> 31 edges of work -> result held until taken.
  logic        m_idle  = 1'b1;
  logic        m_valid = 1'b0;
  int          m_rem   = 0;
  logic [32:0] m_pend  = '0;
  logic [31:0] m_prod  = '0;
  logic        m_ovf   = 1'b0;
  int          m_acc   = 0;
  int          m_res   = 0;
  int          d_res   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle  = 1'b1;
      m_valid = 1'b0;
      m_rem   = 0;
      m_prod  = '0;
      m_ovf   = 1'b0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_pend = ref_mul(op1, op2);
        m_idle = 1'b0;
        m_rem  = 31;
        m_acc++;
      end
    end else if (!m_valid) begin
      m_rem--;
      if (m_rem == 0) begin
        m_valid = 1'b1;
        m_prod  = m_pend[31:0];
        m_ovf   = m_pend[32];
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
      m_idle  = 1'b1;
      m_res++;
    end
  end

  // DUT-side count of delivered results.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) d_res++;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cyc_in_ready", {63'd0, in_ready}, {63'd0, m_idle});
    chk("cyc_out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    chk("cyc_prod", {32'd0, prod}, {32'd0, m_prod});
    chk("cyc_ovf", {63'd0, ovf}, {63'd0, m_ovf});
  end

  // Issue one op, wait for its result, check latency and literal result, then take it.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ep, input logic eo, input string nm);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; op1 = a; op2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0; op1 = $urandom; op2 = $urandom;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"}, 64'(lat), 64'd31);
    chk({nm, "_prod"}, {32'd0, prod}, {32'd0, ep});
    chk({nm, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    case ($urandom_range(7))
      0: v = 32'h0000_0000;
      1: v = 32'h8000_0000;
      2: v = {$urandom_range(1), 31'h7FFF_FFFF};
      3: v = {$urandom_range(1), 15'd0, 16'($urandom)};
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int lat;
    int base;
    int cyc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op1 = '0; op2 = '0;

    // Pin the reference arithmetic with hand-computed values.
    chk("pin_3x-5", {31'd0, ref_mul(32'h0000_0003, 32'h8000_0005)}, {31'd0, 1'b0, 32'h8000_000F});
    chk("pin_0x-7", {31'd0, ref_mul(32'h0000_0000, 32'h8000_0007)}, {31'd0, 1'b0, 32'h0000_0000});
    chk("pin_-0x-3", {31'd0, ref_mul(32'h8000_0000, 32'h8000_0003)}, {31'd0, 1'b0, 32'h0000_0000});
    chk("pin_max3", {31'd0, ref_mul(32'h7FFF_FFFF, 32'h0000_0003)}, {31'd0, 1'b1, 32'h7FFF_FFFD});
    chk("pin_2^32", {31'd0, ref_mul(32'hC000_0000, 32'h0000_0004)}, {31'd0, 1'b1, 32'h0000_0000});

    #22;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_prod", {32'd0, prod}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    rst = 1'b0;

    run_op(32'h0000_0003, 32'h8000_0005, 32'h8000_000F, 1'b0, "d_3x-5");
    run_op(32'h0000_0000, 32'h8000_0007, 32'h0000_0000, 1'b0, "d_0x-7");
    run_op(32'h8000_0000, 32'h8000_0003, 32'h0000_0000, 1'b0, "d_-0x-3");
    run_op(32'h7FFF_FFFF, 32'h0000_0003, 32'h7FFF_FFFD, 1'b1, "d_max3");
    run_op(32'hC000_0000, 32'h0000_0004, 32'h0000_0000, 1'b1, "d_2^32");

    // Backpressure: result held for 5 cycles while new operands are offered.
    @(posedge clk); #1;
    in_valid = 1'b1; op1 = 32'h0000_0006; op2 = 32'h0000_0002;
    @(posedge clk); #1;
    op1 = 32'h8000_0009; op2 = 32'h0000_0003;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_lat", 64'(lat), 64'd31);
    for (int i = 0; i < 5; i++) begin
      chk("bp_prod", {32'd0, prod}, 64'h0000_000C);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      op1 = $urandom; op2 = $urandom;
      @(posedge clk); #1;
    end
    chk("bp_still_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_prod_end", {32'd0, prod}, 64'h0000_000C);
    op1 = 32'h8000_0009; op2 = 32'h0000_0003;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accepted", {63'd0, in_ready}, 64'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp2_lat", 64'(lat), 64'd31);
    chk("bp2_prod", {32'd0, prod}, 64'h8000_001B);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Asynchronous abort mid-computation.
    @(posedge clk); #1;
    in_valid = 1'b1; op1 = 32'h0000_0009; op2 = 32'h0000_0009;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_prod", {32'd0, prod}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    #2;
    rst = 1'b0;
    run_op(32'h0000_0006, 32'h8000_0007, 32'h8000_002A, 1'b0, "d_after_rst");

    // Back-to-back random stream with random downstream stalls.
    @(posedge clk); #1;
    base = m_acc;
    in_valid = 1'b1;
    cyc = 0;
    while (m_acc - base < 1000 && cyc < 60000) begin
      op1 = rand_op(); op2 = rand_op();
      out_ready = ($urandom_range(3) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_ops_issued", 64'(m_acc - base), 64'd1000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (!(m_idle && !m_valid) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_drained", {63'd0, m_idle}, 64'd1);
    chk("result_count", 64'(d_res), 64'(m_res));
    out_ready = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sm_mul32.md
SM_MUL32 -- requirements
Module: sm_mul32

Interface
REQ-001 Block SHALL have no parameters; operand and result width fixed at 32 bits, sign-magnitude format (bit 31 sign, bits 30:0 magnitude).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operand pair valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 op1  input  32  multiplicand, sign-magnitude (as produced by the TCC converter stage).
REQ-007 op2  input  32  multiplier, sign-magnitude.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  downstream (CTC converter stage) accepts result.
REQ-010 prod  output  32  product, sign-magnitude, low 31 magnitude bits.
REQ-011 ovf  output  1  product magnitude exceeds 31 bits.

Function
REQ-012 FSM states SHALL be IDLE, BUSY, DONE; encoding is free.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 IDLE: on edge with in_valid=1 -> latch sign=op1[31]^op2[31], mcand=op1[30:0], mplier=op2[30:0], 62-bit acc=0, 5-bit count=0; go BUSY.
REQ-015 BUSY: each edge, if mplier bit[count]=1 then acc += mcand<<count (62-bit, no truncation); count increments.
REQ-016 BUSY SHALL last exactly 31 edges (count 0..30); at edge with count=30 -> DONE; no early termination on zero operands.
REQ-017 Latency: accept at edge E0 -> out_valid visible after edge E31 (31 cycles), fixed, data-independent.
REQ-018 DONE: prod[30:0]=acc[30:0]; ovf=|acc[61:31]; prod[31]=sign AND (acc[30:0]!=0).
REQ-019 Zero-magnitude result SHALL be encoded +0 (0x00000000); -0 never produced; input -0 (0x80000000) treated as magnitude 0.
REQ-020 prod and ovf SHALL stay stable while out_valid=1 and out_ready=0 (unbounded backpressure).
REQ-021 DONE: edge with out_ready=1 -> IDLE; new operands accepted no earlier than next edge (no same-cycle turnaround).
REQ-022 in_valid and op1/op2 SHALL be ignored outside IDLE; operands sampled only at accept edge.
REQ-023 prod/ovf outside DONE SHALL hold last computed value (0 after reset); consumers qualify with out_valid.

Reset
REQ-024 rst=1 SHALL immediately (without clock) force IDLE, out_valid=0, prod=0x00000000, ovf=0, acc=0, count=0; in_ready=1 while in IDLE.
REQ-025 rst asserted in BUSY or DONE SHALL abort operation; aborted result never presented; after release first accept proceeds normally.

Verification
REQ-026 op1=0x00000003, op2=0x80000005 -> after 31 cycles prod=0x8000000F, ovf=0.
REQ-027 op1=0x00000000, op2=0x80000007 -> prod=0x00000000 (not 0x80000000), ovf=0; op1=0x80000000, op2=0x80000003 -> prod=0x00000000.
REQ-028 op1=0x7FFFFFFF, op2=0x00000003 -> prod=0x7FFFFFFD, ovf=1; op1=0xC0000000, op2=0x00000004 -> prod=0x00000000, ovf=1.
REQ-029 Backpressure: result ready, out_ready low 5 cycles while in_valid=1 with new operands -> prod/ovf stable, in_ready=0, new operands not taken; out_ready=1 -> IDLE, next edge accepts.
REQ-030 rst pulsed mid-clock at BUSY cycle 10 -> out_valid=0, prod=0, in_ready=1 immediately; subsequent 0x00000006 x 0x80000007 -> prod=0x8000002A after 31 cycles.
REQ-031 Random back-to-back stream (>=1000 ops) vs reference model: exact prod/ovf, latency always 31, every accepted op produces exactly one result in order.
